// File: rtl/edge_delay_monitor.sv
// Multi-channel edge monitor: each selected edge starts a per-channel delay,
// then fires a one-cycle pulse and queues the channel ID in an event FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | channel waiting for a selected edge on sig_in[c]
// ST_COUNT | delay running; fires when cnt reaches 0, then re-arms or idles
module edge_delay_monitor #(
    parameter int NCH   = 4,
    parameter int DLY_W = 8,
    parameter int DEPTH = 8,
    localparam int IDW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   sig_in,
    input  logic [2*NCH-1:0] edge_mode,
    input  logic [DLY_W-1:0] delay,
    input  logic             clr,
    output logic [NCH-1:0]   evt_pulse,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    input  logic             evt_ready,
    output logic [CW-1:0]    fifo_count,
    output logic [NCH-1:0]   overrun
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } ch_state_t;

    ch_state_t        state_q [NCH];
    ch_state_t        state_d [NCH];
    logic [DLY_W-1:0] cnt_q   [NCH];
    logic [DLY_W-1:0] cnt_d   [NCH];

    logic [NCH-1:0] sig_q;
    logic [NCH-1:0] det;
    logic [NCH-1:0] fire;
    logic [NCH-1:0] ovr_edge;
    logic [NCH-1:0] ovr_set;
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] req_oh;
    logic [NCH-1:0] grant;
    logic [IDW-1:0] req_id;
    logic           fifo_full;
    logic           push;
    logic           pop;

    logic [IDW-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    always_comb begin
        det = '0;
        for (int c = 0; c < NCH; c++) begin
            det[c] = (edge_mode[2*c]   &  sig_in[c] & ~sig_q[c]) |
                     (edge_mode[2*c+1] & ~sig_in[c] &  sig_q[c]);
        end
    end

    // An edge landing on the fire cycle is not an overrun: fire and reload together.
    always_comb begin
        fire     = '0;
        ovr_edge = '0;
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    if (det[c]) begin
                        state_d[c] = ST_COUNT;
                        cnt_d[c]   = delay;
                    end
                end
                ST_COUNT: begin
                    if (cnt_q[c] == '0) begin
                        fire[c] = 1'b1;
                        if (det[c]) begin
                            cnt_d[c] = delay;
                        end else begin
                            state_d[c] = ST_IDLE;
                        end
                    end else begin
                        cnt_d[c] = cnt_q[c] - 1'b1;
                        if (det[c]) begin
                            ovr_edge[c] = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                    cnt_d[c]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        req_oh = '0;
        req_id = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (pend_q[c]) begin
                req_oh    = '0;
                req_oh[c] = 1'b1;
                req_id    = IDW'(c);
            end
        end
    end

    assign evt_valid = (fifo_count != '0);
    assign fifo_full = (fifo_count == CW'(DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign push      = (pend_q != '0) && (!fifo_full || pop);
    assign grant     = push ? req_oh : '0;
    assign evt_id    = evt_valid ? mem[rd_ptr] : '0;

    // A fire onto a pend bit that is not leaving this cycle loses the event.
    assign pend_d  = (pend_q & ~grant) | fire;
    assign ovr_set = ovr_edge | (fire & pend_q & ~grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q      <= sig_in;
            pend_q     <= '0;
            evt_pulse  <= '0;
            overrun    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
            end
        end else begin
            sig_q     <= sig_in;
            pend_q    <= pend_d;
            evt_pulse <= fire;
            overrun   <= (overrun & ~{NCH{clr}}) | ovr_set;
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= req_id;
        end
    end

endmodule

// File: doc/edge_delay_monitor.md
# edge_delay_monitor

Multi-channel, synthesizable event monitor that watches NCH single-bit signals for programmable edges. After a programmable delay it fires a per-channel one-cycle pulse and queues the channel ID in an event FIFO, read through a valid/ready handshake. It is the parametrised, clocked successor of our behavioural "edge then delayed message" monitors, and sits beside datapath blocks as a trace/debug event source.

## Interface
Parameters:
- NCH, 4, number of monitored channels (≥1)
- DLY_W, 8, width of the delay value
- DEPTH, 8, event FIFO depth (power of 2, ≥2)

Ports:
- clk  input  1  clock; all logic is on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- sig_in  input  NCH  monitored signals, synchronous to clk
- edge_mode  input  2*NCH  per channel, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
- delay  input  DLY_W  delay in cycles, shared by all channels, sampled at detection
- clr  input  1  clears sticky overrun flags
- evt_pulse  output  NCH  one-cycle fire pulse per channel
- evt_valid  output  1  FIFO not empty
- evt_id  output  max(1,$clog2(NCH))  channel ID at FIFO head
- evt_ready  input  1  consumer accepts head
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy
- overrun  output  NCH  sticky per-channel dropped-event flag

## Operation
- sig_q holds sig_in from the previous cycle. Channel c detects an edge when sig_in[c] != sig_q[c] and the direction matches edge_mode.
- Per-channel state is IDLE or COUNT.
  - On detection in IDLE: go to COUNT with cnt <= delay.
  - In COUNT with cnt != 0: cnt decrements.
  - In COUNT with cnt == 0: fire. evt_pulse[c] is 1 for the next cycle, pend[c] is set, and the channel returns to IDLE.
- Edge in COUNT on a non-fire cycle: the edge is dropped and overrun[c] is set.
- Edge on the fire cycle: the fire occurs and the new edge is accepted, reloading cnt <= delay. No overrun.
- Fire while pend[c] is already set: pend stays 1, the event is lost, and overrun[c] is set.
- Arbiter: each cycle, the lowest-index set pend bit is pushed as its ID into the FIFO and that pend bit is cleared.
  - Push is allowed when fifo_count < DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
  - If the FIFO is full with no pop, pend is held (backpressure).
- Pop when evt_valid && evt_ready. evt_id shows the head and is 0 when empty. Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo DEPTH. fifo_count is a registered output.
- clr clears overrun. If a set and clr hit the same bit in the same cycle, set wins.
- A change to delay or edge_mode mid-count does not affect running counts. Setting edge_mode to 00 mid-count does not cancel the pending fire.

## Timing
- Reset (rst_n low at a posedge) drives all channels to IDLE and cnt = 0, and clears pend, FIFO pointers, evt_pulse, fifo_count, evt_valid, evt_id and overrun.
- During reset sig_q <= sig_in, so no edge is reported on the first cycle after reset. Reset mid-count or with a non-empty FIFO discards all events.
- Latency, with the edge sampled at posedge k:
  - evt_pulse is high between posedge k+D+1 and k+D+2.
  - The earliest evt_valid is after posedge k+D+2.
- Minimum edge spacing for a clean re-arm is D+1 cycles.
- Throughput: the FIFO accepts at most one push per cycle and delivers at most one pop per cycle.

## Test plan
- Rise, D=3: edge_mode=01 and sig_in[0] 0→1 sampled at posedge 10 → evt_pulse[0] high in the cycle after posedge 14, then evt_valid with evt_id=0 after posedge 15.
- D=0 on both edges: edge_mode=11 and a 1→0 edge on channel 2 → pulse one cycle after detection, ID 2 queued. A fall on a channel with edge_mode=01 → nothing.
- Re-trigger: D=5, with a second edge 2 cycles after the first → exactly one pulse and overrun[c]=1. clr pulse → overrun=0. An edge exactly on the fire cycle → two pulses, no overrun.
- Simultaneous fire on channels 3, 1 and 0 → pulses in the same cycle; FIFO receives IDs 0, 1, 3 on consecutive cycles.
- Backpressure, DEPTH=8: evt_ready=0 and 9 events → fifo_count=8, the ninth stays pending. A further fire on that channel → overrun. Raising evt_ready → the IDs drain in order, and the pending ID enters during the full+pop cycle.
- Reset mid-operation: rst_n low for 1 cycle with 3 queued IDs and an active count → all outputs 0 and no spurious pulse after release, even with sig_in=1 held.
